// File: rtl/bcd_counter_multi.sv
// Multi-decade BCD up/down counter with validated parallel load and registered wrap/error pulses.
// Optional macro BCD_COUNTER_SATURATE_EN: hold at the terminal value and pulse carry_out instead of wrapping.
module bcd_counter_multi #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  done,
  output logic                  carry_out,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] r_q;
  logic                r_carry;
  logic                r_err;

  logic [4*DIGITS-1:0] w_next;
  logic                w_chain;
  logic [3:0]          w_dig;
  logic                w_load_ok;

  function automatic logic all_digits_eq(input logic [4*DIGITS-1:0] v, input logic [3:0] d);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      eq = eq & (v[4*i +: 4] == d);
    end
    return eq;
  endfunction

  function automatic logic is_bcd(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & (v[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  assign done      = up_dn ? all_digits_eq(r_q, 4'd9) : all_digits_eq(r_q, 4'd0);
  assign w_load_ok = is_bcd(load_val);

  // A decade steps only while every lower decade sits at its rollover digit.
  always_comb begin
    w_next  = r_q;
    w_chain = 1'b1;
    w_dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig = r_q[4*i +: 4];
      if (w_chain) begin
        if (up_dn) w_next[4*i +: 4] = (w_dig == 4'd9) ? 4'd0 : 4'(w_dig + 4'd1);
        else       w_next[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : 4'(w_dig - 4'd1);
      end
      w_chain = w_chain & (up_dn ? (w_dig == 4'd9) : (w_dig == 4'd0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      if (load) begin
        if (w_load_ok) r_q   <= load_val;
        else           r_err <= 1'b1;
      end else if (enable) begin
`ifdef BCD_COUNTER_SATURATE_EN
        if (done) r_carry <= 1'b1;
        else      r_q     <= w_next;
`else
        r_q     <= w_next;
        r_carry <= done;
`endif
      end
    end
  end

  assign Q         = r_q;
  assign carry_out = r_carry;
  assign load_err  = r_err;

endmodule
